// File: rtl/thor2021_btb_upd_ctrl.sv
// BTB write sequencer: full-table invalidate walk after reset/flush, then an
// in-order drain of a small queue fed by two branch-resolution update ports.
module thor2021_btb_upd_ctrl #(
    parameter int AWID    = 64,
    parameter int ENTRIES = 1024,
    parameter int QDEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_req,
    output logic            busy,
    input  logic            upd0_v,
    input  logic [AWID-1:0] upd0_ip,
    input  logic [AWID-1:0] upd0_tgt,
    input  logic            upd0_takb,
    output logic            upd0_rdy,
    input  logic            upd1_v,
    input  logic [AWID-1:0] upd1_ip,
    input  logic [AWID-1:0] upd1_tgt,
    input  logic            upd1_takb,
    output logic            upd1_rdy,
    output logic            btb_wr,
    output logic [AWID-1:0] btb_wip,
    output logic [AWID-1:0] btb_wtgt,
    output logic            btb_takb
);

    localparam int IW = $clog2(ENTRIES);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_FLUSH} state_e;

    typedef struct packed {
        logic [AWID-1:0] ip;
        logic [AWID-1:0] tgt;
        logic            takb;
    } upd_t;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            wr_q, wr_d;
    logic [AWID-1:0] wip_q, wip_d;
    logic [AWID-1:0] wtgt_q, wtgt_d;
    logic            takb_q, takb_d;

    upd_t            q_mem [QDEPTH];

    logic            walking;
    logic            walk_load;
    logic [IW-1:0]   walk_idx;
    logic            walk_last;
    logic [CW-1:0]   free;
    logic            run_open;
    logic            push0, push1, pop;
    logic [PW-1:0]   slot1;

    // A flush always wins: it (re)starts the walk at index 0 in any state.
    assign walking   = (state_q != S_RUN);
    assign walk_load = flush_req || walking;
    assign walk_idx  = flush_req ? '0 : idx_q;
    assign walk_last = (walk_idx == IW'(ENTRIES - 1));
    assign free      = CW'(QDEPTH) - cnt_q;
    assign push0     = upd0_v && upd0_rdy && !flush_req;
    assign push1     = upd1_v && upd1_rdy && !flush_req;
    assign pop       = run_open && !flush_req && (cnt_q != '0);
    assign slot1     = push0 ? tail_q + PW'(1) : tail_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    // NOTE: every signal driven in an always_comb gets a default on entry so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        if (flush_req && (state_q == S_RUN)) begin
            state_d = S_FLUSH;
        end
        if (walk_load && walk_last) begin
            state_d = S_RUN;
        end
    end

    // Datapath next values: walk writes, queue pointers, registered BTB port
    always_comb begin
        idx_d  = idx_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        busy_d = walk_load;
        wr_d   = 1'b0;
        wip_d  = wip_q;
        wtgt_d = wtgt_q;
        takb_d = takb_q;
        if (walk_load) begin
            wr_d   = 1'b1;
            wip_d  = AWID'(walk_idx) << 1;
            wtgt_d = '0;
            takb_d = 1'b0;
            idx_d  = walk_last ? '0 : walk_idx + IW'(1);
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) begin
                wr_d   = 1'b1;
                wip_d  = q_mem[head_q].ip;
                wtgt_d = q_mem[head_q].tgt;
                takb_d = q_mem[head_q].takb;
                head_d = head_q + PW'(1);
            end
            tail_d = tail_q + PW'(push0) + PW'(push1);
            cnt_d  = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            wr_q   <= 1'b0;
            wip_q  <= '0;
            wtgt_q <= '0;
            takb_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            wr_q   <= wr_d;
            wip_q  <= wip_d;
            wtgt_q <= wtgt_d;
            takb_q <= takb_d;
        end
    end

    // NOTE: queue storage has no reset; validity is tracked solely by the count and pointers.
    always_ff @(posedge clk) begin
        if (push0) begin
            q_mem[tail_q] <= '{ip: upd0_ip, tgt: upd0_tgt, takb: upd0_takb};
        end
        if (push1) begin
            q_mem[slot1] <= '{ip: upd1_ip, tgt: upd1_tgt, takb: upd1_takb};
        end
    end

    // Outputs; busy stays high through the cycle showing the final walk write
    always_comb begin
        run_open = (state_q == S_RUN) && !busy_q;
        upd0_rdy = run_open && (free >= CW'(1));
        upd1_rdy = run_open && (free >= CW'(2));
        busy     = busy_q;
    end

    assign btb_wr   = wr_q;
    assign btb_wip  = wip_q;
    assign btb_wtgt = wtgt_q;
    assign btb_takb = takb_q;

endmodule
